// File: rtl/switch_press_counter.sv
// Push-button press counter: 2-flop synchroniser, debounce filter, wrapping press count (count on release, DEBOUNCE_LIMIT+2 edges after a stable raw change).
// Optional auto-repeat while held is enabled by defining SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN.
module switch_press_counter #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int COUNT_WIDTH    = 2,
  parameter int REPEAT_LIMIT   = 12500000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Switch,
  output logic [COUNT_WIDTH-1:0] o_Binary_Number,
  output logic                   o_Press_Pulse,
  output logic                   o_Switch_Debounced
);

  localparam int              DEB_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_LIMIT - 1);

  if (DEBOUNCE_LIMIT < 2 || REPEAT_LIMIT < 2) begin : g_bad_params
    $error("switch_press_counter: DEBOUNCE_LIMIT and REPEAT_LIMIT must be >= 2");
  end

`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
  localparam int              REP_W    = $clog2(REPEAT_LIMIT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  logic [REP_W-1:0] rep_timer;
`else
  typedef enum logic [1:0] {IDLE, PRESSED} state_t;
`endif

  logic                   sync_meta;
  logic                   sync_q;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   debounced;
  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic                   pulse;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= i_Switch;
      sync_q    <= sync_meta;
    end
  end

  // Any sample agreeing with the accepted level restarts the qualification window.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb_cnt   <= '0;
      debounced <= 1'b0;
    end else if (sync_q == debounced) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      debounced <= sync_q;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      count <= '0;
      pulse <= 1'b0;
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
      rep_timer <= '0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (debounced) begin
            state <= PRESSED;
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
            rep_timer <= '0;
`endif
          end
        end
        PRESSED: begin
          // Release wins over a repeat expiring on the same edge.
          if (!debounced) begin
            state <= IDLE;
            count <= count + COUNT_WIDTH'(1);
            pulse <= 1'b1;
          end
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
          else if (rep_timer == REP_LAST) begin
            state     <= REPEAT;
            count     <= count + COUNT_WIDTH'(1);
            pulse     <= 1'b1;
            rep_timer <= '0;
          end else begin
            rep_timer <= rep_timer + REP_W'(1);
          end
`endif
        end
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
        REPEAT: begin
          if (!debounced) begin
            state <= IDLE;
          end else if (rep_timer == REP_LAST) begin
            count     <= count + COUNT_WIDTH'(1);
            pulse     <= 1'b1;
            rep_timer <= '0;
          end else begin
            rep_timer <= rep_timer + REP_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Binary_Number    = count;
  assign o_Press_Pulse      = pulse;
  assign o_Switch_Debounced = debounced;

endmodule

// File: tb/tb_switch_press_counter.sv
// Bench for switch_press_counter: directed scenarios plus random button activity against an edge-indexed reference model.
module tb_switch_press_counter;

  localparam int DL  = 4;
  localparam int CW  = 2;
  localparam int RL  = 8;
  localparam int N   = 16384;
  localparam int OFS = 8;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b0;
  logic          i_Switch = 1'b0;
  logic [CW-1:0] o_Binary_Number;
  logic          o_Press_Pulse;
  logic          o_Switch_Debounced;

  int vectors = 0;
  int miscompares = 0;
  int dut_pulses = 0;
  int deb_hi = 0;
  logic prev_pulse = 1'b0;

  switch_press_counter #(
    .DEBOUNCE_LIMIT(DL),
    .COUNT_WIDTH   (CW),
    .REPEAT_LIMIT  (RL)
  ) dut (
    .i_Clk             (i_Clk),
    .i_Rst_L           (i_Rst_L),
    .i_Switch          (i_Switch),
    .o_Binary_Number   (o_Binary_Number),
    .o_Press_Pulse     (o_Press_Pulse),
    .o_Switch_Debounced(o_Switch_Debounced)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: raw_h[j] is the button as sampled by edge j, deb_h[j] the filtered level after edge j.
  bit raw_h [0:N-1];
  bit deb_h [0:N-1];
  int k = OFS;
  bit held = 1'b0;
  int press_edge = 0;
  int reps = 0;
  int m_count = 0;
  bit m_pulse = 1'b0;
  logic          e_deb = 1'b0;
  logic          e_pulse = 1'b0;
  logic [CW-1:0] e_cnt = '0;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      k = OFS; held = 1'b0; press_edge = 0; reps = 0; m_count = 0; m_pulse = 1'b0;
      for (int i = 0; i <= OFS; i++) begin
        raw_h[i] = 1'b0;
        deb_h[i] = 1'b0;
      end
    end else begin
      bit all_diff;
      k = k + 1;
      raw_h[k] = i_Switch;
      // Level is accepted once the last DL synchronised samples all disagree with it.
      all_diff = 1'b1;
      for (int i = 0; i < DL; i++)
        if (raw_h[k-2-i] == deb_h[k-1]) all_diff = 1'b0;
      deb_h[k] = all_diff ? ~deb_h[k-1] : deb_h[k-1];
      m_pulse = 1'b0;
      if (!held && deb_h[k-1]) begin
        held = 1'b1; press_edge = k; reps = 0;
      end else if (held && !deb_h[k-1]) begin
        held = 1'b0;
        if (reps == 0) begin
          m_count = (m_count + 1) % (1 << CW);
          m_pulse = 1'b1;
        end
      end
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
      else if (held && ((k - press_edge) % RL == 0)) begin
        reps++;
        m_count = (m_count + 1) % (1 << CW);
        m_pulse = 1'b1;
      end
`endif
    end
    e_deb   = (i_Rst_L === 1'b1) ? deb_h[k] : 1'b0;
    e_cnt   = CW'(m_count);
    e_pulse = m_pulse;
  end

  always @(negedge i_Clk) begin
    vectors++;
    if (o_Switch_Debounced !== e_deb || o_Binary_Number !== e_cnt ||
        o_Press_Pulse !== e_pulse || (o_Press_Pulse === 1'b1 && prev_pulse === 1'b1)) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t: dut deb=%b cnt=%0d pulse=%b (prev %b), model deb=%b cnt=%0d pulse=%b",
               $time, o_Switch_Debounced, o_Binary_Number, o_Press_Pulse, prev_pulse, e_deb, e_cnt, e_pulse);
    end
    prev_pulse = o_Press_Pulse;
    if (o_Press_Pulse === 1'b1) dut_pulses++;
    if (o_Switch_Debounced === 1'b1) deb_hi++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
    #1;
  endtask

  task automatic press(input int hold, input int gap);
    i_Switch = 1'b1; tick(hold);
    i_Switch = 1'b0; tick(gap);
  endtask

  task automatic pulse_reset();
    i_Rst_L = 1'b0; tick(1);
    i_Rst_L = 1'b1; tick(1);
  endtask

  int p0, d0;

  initial begin
    // Reset asserted asynchronously while a debounced press is active.
    tick(3);
    i_Rst_L = 1'b1; tick(2);
    i_Switch = 1'b1; tick(8);
    check("pre_reset_deb", o_Switch_Debounced, 1);
    @(posedge i_Clk); #2;
    i_Rst_L = 1'b0; #1;
    check("async_rst_deb", o_Switch_Debounced, 0);
    check("async_rst_cnt", o_Binary_Number, 0);
    check("async_rst_pulse", o_Press_Pulse, 0);
    i_Switch = 1'b0; tick(2);
    i_Rst_L = 1'b1;
    p0 = dut_pulses; d0 = deb_hi;
    tick(5);
    check("post_rst_cnt", o_Binary_Number, 0);
    check("post_rst_pulses", dut_pulses - p0, 0);
    check("post_rst_deb_hi", deb_hi - d0, 0);

    // Clean press: edge timing of the filter and the count-on-release.
    p0 = dut_pulses;
    i_Switch = 1'b1; tick(5);
    check("press_deb_e4", o_Switch_Debounced, 0);
    tick(1);
    check("press_deb_e5", o_Switch_Debounced, 1);
    tick(6);
    i_Switch = 1'b0;
`ifndef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
    tick(5);
    check("rel_deb_e4", o_Switch_Debounced, 1);
    tick(1);
    check("rel_deb_e5", o_Switch_Debounced, 0);
    check("rel_cnt_e5", o_Binary_Number, 0);
    tick(1);
    check("rel_cnt_e6", o_Binary_Number, 1);
    check("rel_pulse_e6", o_Press_Pulse, 1);
    tick(1);
    check("rel_pulse_e7", o_Press_Pulse, 0);
    tick(3);
`else
    tick(10);
`endif
    check("clean_cnt", o_Binary_Number, 1);
    check("clean_model_cnt", m_count, 1);
    check("clean_pulses", dut_pulses - p0, 1);

    // Bounce shorter than the filter window.
    p0 = dut_pulses; d0 = deb_hi;
    press(3, 2);
    press(3, 10);
    check("bounce_deb_hi", deb_hi - d0, 0);
    check("bounce_pulses", dut_pulses - p0, 0);
    check("bounce_cnt", o_Binary_Number, 1);

    // Wrap through four presses.
    pulse_reset();
    for (int p = 1; p <= 4; p++) begin
      p0 = dut_pulses;
      press(8, 10);
      check("wrap_cnt", o_Binary_Number, p % 4);
      check("wrap_model_cnt", m_count, p % 4);
      check("wrap_pulses", dut_pulses - p0, 1);
    end

    // Reset while a release is two samples into the filter.
    press(8, 10);
    check("mid_deb_pre_cnt", o_Binary_Number, 1);
    i_Switch = 1'b1; tick(10);
    p0 = dut_pulses;
    i_Switch = 1'b0; tick(4);
    i_Rst_L = 1'b0; tick(2);
    i_Rst_L = 1'b1; tick(10);
    check("mid_deb_cnt", o_Binary_Number, 0);
    check("mid_deb_pulses", dut_pulses - p0, 0);

    // Long hold.
    pulse_reset();
    p0 = dut_pulses;
    press(40, 12);
`ifdef SWITCH_PRESS_COUNTER_AUTO_REPEAT_EN
    check("hold_pulses", dut_pulses - p0, 4);
    check("hold_cnt", o_Binary_Number, 0);
`else
    check("hold_pulses", dut_pulses - p0, 1);
    check("hold_cnt", o_Binary_Number, 1);
`endif

    // Random button activity with occasional asynchronous resets.
    for (int it = 0; it < 250; it++) begin
      i_Switch = $urandom_range(0, 1);
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 24) == 0) begin
        #($urandom_range(1, 3));
        i_Rst_L = 1'b0;
        tick($urandom_range(1, 3));
        i_Rst_L = 1'b1;
      end
    end
    i_Switch = 1'b0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
